// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
package dmem_responder_pkg;

    localparam int DMEM_WSTRB_W = 4;
    localparam int DMEM_WORD_W  = 32;
    localparam int DMEM_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - four byte-lane storage arrays with per-lane write and registered read
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic                    clk,
    input  logic [AW-1:0]           addr,
    input  logic                    we,
    input  logic [DMEM_WSTRB_W-1:0] wstrb,
    input  logic [DMEM_WORD_W-1:0]  wdata,
    input  logic                    re,
    output logic [DMEM_WORD_W-1:0]  rdata
);

    for (genvar l = 0; l < DMEM_WSTRB_W; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_q;

        // Lane write when its strobe is set; read register only updates on re so it holds for the response
        always_ff @(posedge clk) begin
            if (we && wstrb[l]) begin
                mem[addr] <= wdata[8*l +: 8];
            end
            if (re) begin
                rd_q <= mem[addr];
            end
        end

        assign rdata[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with wait states and range check
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [DMEM_WSTRB_W-1:0] req_wstrb,
    input  logic [DMEM_WORD_W-1:0]  req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DMEM_WORD_W-1:0]  rsp_rdata,
    output logic                    rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Window bounds carried in 33 bits so a window touching 2^32 does not wrap
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(DEPTH_WORDS) << 2);

    dmem_state_e               state_q;
    logic [DMEM_CNT_W-1:0]     cnt_q;
    logic                      we_q;
    logic                      in_range_q;
    logic [AW-1:0]             idx_q;
    logic [DMEM_WSTRB_W-1:0]   wstrb_q;
    logic [DMEM_WORD_W-1:0]    wdata_q;

    logic [31:0]               addr_off;
    logic [AW-1:0]             req_idx;
    logic                      req_in_range;
    logic                      unused_addr_bits;

    logic                      cur_we;
    logic                      cur_in_range;
    logic [AW-1:0]             cur_idx;
    logic [DMEM_WSTRB_W-1:0]   cur_wstrb;
    logic [DMEM_WORD_W-1:0]    cur_wdata;

    logic                      enter_resp;
    logic                      bank_we;
    logic                      bank_re;
    logic [DMEM_WORD_W-1:0]    bank_rdata;

    assign addr_off         = req_addr - BASE_ADDR;
    assign req_idx          = addr_off[AW+1:2];
    assign req_in_range     = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    assign unused_addr_bits = ^{addr_off[31:AW+2], addr_off[1:0]};

    // With no wait states the bank is accessed on the handshake edge itself, so take the live request then
    always_comb begin
        cur_we       = we_q;
        cur_in_range = in_range_q;
        cur_idx      = idx_q;
        cur_wstrb    = wstrb_q;
        cur_wdata    = wdata_q;
        if (state_q == IDLE) begin
            cur_we       = req_we;
            cur_in_range = req_in_range;
            cur_idx      = req_idx;
            cur_wstrb    = req_wstrb;
            cur_wdata    = req_wdata;
        end
    end

    // Gated by rst_n so a request held during reset cannot touch memory
    assign enter_resp = rst_n &&
                        (((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == '0)));

    assign bank_we = enter_resp && cur_we && cur_in_range;
    assign bank_re = enter_resp && !cur_we && cur_in_range;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk   (clk),
        .addr  (cur_idx),
        .we    (bank_we),
        .wstrb (cur_wstrb),
        .wdata (cur_wdata),
        .re    (bank_re),
        .rdata (bank_rdata)
    );

    // Request latch, wait counter and IDLE -> WAIT -> RESP -> IDLE sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        in_range_q <= req_in_range;
                        idx_q      <= req_idx;
                        wstrb_q    <= req_wstrb;
                        wdata_q    <= req_wdata;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= DMEM_CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && !in_range_q;
    assign rsp_rdata = ((state_q == RESP) && !we_q && in_range_q) ? bank_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WAITC = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];
    exp_t        exp_q [$];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wstrb (req_wstrb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Response scoreboard: every response handshake pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, e.rdata);
                end
                n_checks++;
                if (rsp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL rsp_err: got %b, required %b", rsp_err, e.err);
                end
            end
        end
    end

    // Issue one request; when expect_rsp is set the model is updated and the expectation queued
    task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input bit expect_rsp);
        exp_t e;
        int   guard;
        bit   inr;
        int   idx;
        guard = 0;
        @(posedge clk); #1;
        while (!req_ready && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: req_ready=%b, required 1", req_ready);
            return;
        end
        inr = ({1'b0, addr} < 33'(DEPTH * 4));
        idx = int'(addr[7:2]);
        e.err   = !inr;
        e.rdata = (we || !inr) ? 32'h0 : model[idx];
        if (expect_rsp) begin
            if (we && inr) begin
                for (int l = 0; l < 4; l++) begin
                    if (strb[l]) model[idx][8*l +: 8] = wdata[8*l +: 8];
                end
            end
            exp_q.push_back(e);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b, required 1", req_ready);
        end
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
        end
        n_checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: err=%b rdata=%h, required 0 00000000", rsp_err, rsp_rdata);
        end
    endtask

    task automatic test_basic();
        send(1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b1);
        send(1'b1, 32'h0000_0020, 4'hF, 32'h55AA_55AA, 1'b1);
        send(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1);
        send(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
        send(1'b1, 32'h0000_0012, 4'b0100, 32'h00AB_0000, 1'b1);
        send(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
        drain();
    endtask

    task automatic test_backpressure();
        int          lat;
        bit          ready_bad;
        bit          stable_bad;
        logic [31:0] hold_rd;
        logic        hold_err;
        rsp_ready = 1'b0;
        send(1'b0, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF, 1'b1);
        lat       = 0;
        ready_bad = 1'b0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            if (req_ready) ready_bad = 1'b1;
            lat++;
            @(negedge clk);
        end
        n_checks++;
        if (lat != WAITC) begin
            n_fail++;
            $display("FAIL rsp_latency: rsp_valid after %0d cycles, required %0d", lat + 1, WAITC + 1);
        end
        hold_rd    = rsp_rdata;
        hold_err   = rsp_err;
        stable_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== hold_rd || rsp_err !== hold_err) stable_bad = 1'b1;
            if (req_ready) ready_bad = 1'b1;
        end
        n_checks++;
        if (stable_bad) begin
            n_fail++;
            $display("FAIL rsp_stable: rdata=%h err=%b valid=%b, required held %h %b 1", rsp_rdata, rsp_err, rsp_valid, hold_rd, hold_err);
        end
        n_checks++;
        if (ready_bad) begin
            n_fail++;
            $display("FAIL req_ready_busy: seen 1 while busy, required 0");
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_rsp: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
        end
        drain();
    endtask

    task automatic test_out_of_range();
        send(1'b1, 32'(DEPTH * 4), 4'hF, 32'hFFFF_FFFF, 1'b1);
        send(1'b0, 32'h0000_0000, 4'h0, 32'h0, 1'b1);
        send(1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 1'b1);
        send(1'b1, 32'h8000_0010, 4'hF, 32'h0BAD_0BAD, 1'b1);
        send(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
        drain();
    endtask

    task automatic test_reset_in_wait();
        send(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, 1'b0);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_wait: rsp_valid=%b req_ready=%b, required 0 0", rsp_valid, req_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_async: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(1'b0, 32'h0000_0020, 4'hF, 32'hFFFF_FFFF, 1'b1);
        drain();
    endtask

    task automatic test_reset_in_resp();
        int guard;
        rsp_ready = 1'b0;
        send(1'b0, 32'h0000_0000, 4'h0, 32'h0, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_reached: rsp_valid=%b, required 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp_drop: valid=%b rdata=%h err=%b, required 0 00000000 0", rsp_valid, rsp_rdata, rsp_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_zero_strobe();
        send(1'b1, 32'h0000_0010, 4'b0000, 32'h1111_1111, 1'b1);
        send(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 16; i < 24; i++) begin
            send(1'b1, 32'(i * 4), 4'hF, $urandom, 1'b1);
        end
        for (int i = 0; i < 30; i++) begin
            w = 16 + $urandom_range(0, 7);
            send(1'($urandom_range(0, 1)), 32'(w * 4) | 32'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), $urandom, 1'b1);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_out_of_range();
        test_reset_in_wait();
        test_reset_in_resp();
        test_zero_strobe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
